// File: rtl/bist_sequencer_if.sv
// bist_sequencer_if: control and status bundle between the BIST sequencer and its TPG/ORA/FIL neighbours
interface bist_sequencer_if #(
  parameter int ERR_BITS   = 8,
  parameter int FAULT_BITS = 8
);
  logic                  start;
  logic                  abort;
  logic                  tpg_end;
  logic                  ora_res;
  logic                  fil_end;
  logic                  tpg_reset;
  logic                  fil_inc;
  logic [ERR_BITS-1:0]   err_count;
  logic [FAULT_BITS-1:0] det_count;
  logic [FAULT_BITS-1:0] fault_idx;
  logic                  busy;
  logic                  done;
  logic                  timeout_err;
  modport master (
    output start, abort, tpg_end, ora_res, fil_end,
    input  tpg_reset, fil_inc, err_count, det_count, fault_idx, busy, done, timeout_err
  );
  modport slave (
    input  start, abort, tpg_end, ora_res, fil_end,
    output tpg_reset, fil_inc, err_count, det_count, fault_idx, busy, done, timeout_err
  );
endinterface

// File: rtl/bist_sequencer.sv
// bist_sequencer: fault-by-fault BIST session FSM driving TPG reset, FIL advance and mismatch counters
module bist_sequencer #(
  parameter int ERR_BITS     = 8,
  parameter int FAULT_BITS   = 8,
  parameter int SETUP_CYCLES = 13,
  parameter int TIMEOUT      = 1024,
  parameter bit EARLY_ABORT  = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  bist_sequencer_if.slave  bus
);
  localparam int SW = $clog2(SETUP_CYCLES + 1);
  localparam int RW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_ADV, S_DONE} state_t;
  state_t                r_state;
  state_t                w_next;
  logic [SW-1:0]         r_setup_cnt;
  logic [RW-1:0]         r_run_cnt;
  logic [ERR_BITS-1:0]   r_err;
  logic [FAULT_BITS-1:0] r_det;
  logic [FAULT_BITS-1:0] r_idx;
  logic                  r_hit;
  logic                  r_tout;
  logic                  w_start;
  logic                  w_setup_last;
  logic                  w_run_last;
  logic                  w_run_exit;
  logic                  w_run_act;
  logic                  w_adv_act;
  always_comb begin
    w_start      = (r_state == S_IDLE || r_state == S_DONE) && bus.start;
    w_setup_last = r_setup_cnt == SW'(SETUP_CYCLES - 1);
    w_run_last   = r_run_cnt == RW'(TIMEOUT - 1);
    w_run_exit   = bus.tpg_end | (EARLY_ABORT & bus.ora_res) | w_run_last;
    w_run_act    = r_state == S_RUN && !bus.abort;
    w_adv_act    = r_state == S_ADV && !bus.abort;
    w_next       = r_state;
    case (r_state)
      S_IDLE:  w_next = bus.start ? S_SETUP : S_IDLE;
      S_SETUP: w_next = bus.abort ? S_IDLE : w_setup_last ? S_RUN : S_SETUP;
      S_RUN:   w_next = bus.abort ? S_IDLE : w_run_exit ? S_ADV : S_RUN;
      S_ADV:   w_next = bus.abort ? S_IDLE : bus.fil_end ? S_DONE : S_RUN;
      S_DONE:  w_next = bus.start ? S_SETUP : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_setup_cnt <= '0;
      r_run_cnt   <= '0;
      r_err       <= '0;
      r_det       <= '0;
      r_idx       <= '0;
      r_hit       <= 1'b0;
      r_tout      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_run_cnt <= (r_state == S_RUN) ? r_run_cnt + 1'b1 : '0;
      if (w_start) begin
        r_setup_cnt <= '0;
        r_err       <= '0;
        r_det       <= '0;
        r_idx       <= '0;
        r_hit       <= 1'b0;
        r_tout      <= 1'b0;
      end else if (r_state == S_SETUP) begin
        r_setup_cnt <= r_setup_cnt + 1'b1;
      end
      if (w_run_act) begin
        if (bus.ora_res) begin
          r_hit <= 1'b1;
          if (r_err != '1) r_err <= r_err + 1'b1;
        end
        if (w_run_last) r_tout <= 1'b1;
      end
      if (w_adv_act) begin
        if (r_idx != '1) r_idx <= r_idx + 1'b1;
        if (r_hit && r_det != '1) r_det <= r_det + 1'b1;
        r_hit <= 1'b0;
      end
    end
  end
  assign bus.tpg_reset   = r_state != S_RUN;
  assign bus.fil_inc     = r_state == S_ADV;
  assign bus.busy        = r_state == S_SETUP || r_state == S_RUN || r_state == S_ADV;
  assign bus.done        = r_state == S_DONE;
  assign bus.err_count   = r_err;
  assign bus.det_count   = r_det;
  assign bus.fault_idx   = r_idx;
  assign bus.timeout_err = r_tout;
endmodule

// File: tb/tb_bist_sequencer.sv
// tb_bist_sequencer: directed checks of four sequencer configurations sharing one gated stimulus
module tb_bist_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic tpg_end = 1'b0;
  logic ora_res = 1'b0;
  logic fil_end = 1'b0;
  int sel = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int n_fil = 0;
  int low;
  logic o_tr, o_fi, o_busy, o_done, o_to;
  logic [31:0] o_err, o_det, o_idx;
  always #5 clk = ~clk;
  bist_sequencer_if ia ();
  bist_sequencer_if ib ();
  bist_sequencer_if #(.ERR_BITS(4)) ic ();
  bist_sequencer_if id ();
  bist_sequencer ua (.clk(clk), .rst_n(rst_n), .bus(ia));
  bist_sequencer #(.EARLY_ABORT(1'b1)) ub (.clk(clk), .rst_n(rst_n), .bus(ib));
  bist_sequencer #(.ERR_BITS(4)) uc (.clk(clk), .rst_n(rst_n), .bus(ic));
  bist_sequencer #(.TIMEOUT(16)) ud (.clk(clk), .rst_n(rst_n), .bus(id));
  assign ia.start = start && sel == 0;
  assign ia.abort = abort && sel == 0;
  assign ia.tpg_end = tpg_end && sel == 0;
  assign ia.ora_res = ora_res && sel == 0;
  assign ia.fil_end = fil_end && sel == 0;
  assign ib.start = start && sel == 1;
  assign ib.abort = abort && sel == 1;
  assign ib.tpg_end = tpg_end && sel == 1;
  assign ib.ora_res = ora_res && sel == 1;
  assign ib.fil_end = fil_end && sel == 1;
  assign ic.start = start && sel == 2;
  assign ic.abort = abort && sel == 2;
  assign ic.tpg_end = tpg_end && sel == 2;
  assign ic.ora_res = ora_res && sel == 2;
  assign ic.fil_end = fil_end && sel == 2;
  assign id.start = start && sel == 3;
  assign id.abort = abort && sel == 3;
  assign id.tpg_end = tpg_end && sel == 3;
  assign id.ora_res = ora_res && sel == 3;
  assign id.fil_end = fil_end && sel == 3;
  always_comb begin
    o_tr = ia.tpg_reset; o_fi = ia.fil_inc; o_busy = ia.busy; o_done = ia.done; o_to = ia.timeout_err;
    o_err = 32'(ia.err_count); o_det = 32'(ia.det_count); o_idx = 32'(ia.fault_idx);
    if (sel == 1) begin
      o_tr = ib.tpg_reset; o_fi = ib.fil_inc; o_busy = ib.busy; o_done = ib.done; o_to = ib.timeout_err;
      o_err = 32'(ib.err_count); o_det = 32'(ib.det_count); o_idx = 32'(ib.fault_idx);
    end else if (sel == 2) begin
      o_tr = ic.tpg_reset; o_fi = ic.fil_inc; o_busy = ic.busy; o_done = ic.done; o_to = ic.timeout_err;
      o_err = 32'(ic.err_count); o_det = 32'(ic.det_count); o_idx = 32'(ic.fault_idx);
    end else if (sel == 3) begin
      o_tr = id.tpg_reset; o_fi = id.fil_inc; o_busy = id.busy; o_done = id.done; o_to = id.timeout_err;
      o_err = 32'(id.err_count); o_det = 32'(id.det_count); o_idx = 32'(id.fault_idx);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic begin_session(input string tag);
    int n = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (o_tr && n < 100) begin
      n++;
      tick();
    end
    chk(tag, n, 13);
  endtask
  task automatic run_fault(input logic [31:0] mask, input int tend, output int c);
    c = 0;
    while (!o_tr && c < 2000) begin
      ora_res = (c < 32) ? mask[c] : 1'b0;
      tpg_end = (c == tend);
      tick();
      c++;
    end
    ora_res = 1'b0;
    tpg_end = 1'b0;
  endtask
  task automatic advance(input string tag, input logic last);
    if (o_fi) n_fil++;
    chk({tag, "_inc"}, o_fi, 1);
    fil_end = last;
    tick();
    fil_end = 1'b0;
    chk({tag, "_pulse"}, o_fi, 0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_tpg_reset", o_tr, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_fil_inc", o_fi, 0);
    chk("rst_err", o_err, 0);
    chk("rst_idx", o_idx, 0);
    rst_n = 1'b1;
    tick();
    begin_session("a_setup");
    chk("a_busy", o_busy, 1);
    run_fault(32'h0, 19, low); chk("a_low0", low, 20); advance("a_adv0", 1'b0);
    run_fault(32'h0, 19, low); chk("a_low1", low, 20); advance("a_adv1", 1'b0);
    run_fault(32'h0, 19, low); chk("a_low2", low, 20); advance("a_adv2", 1'b1);
    tick();
    chk("a_done", o_done, 1);
    chk("a_busy_done", o_busy, 0);
    chk("a_fil_pulses", n_fil, 3);
    chk("a_err", o_err, 0);
    chk("a_det", o_det, 0);
    chk("a_idx", o_idx, 3);
    begin_session("b_setup");
    chk("b_done_cleared", o_done, 0);
    chk("b_idx_cleared", o_idx, 0);
    start = 1'b1;
    run_fault(32'h88, 19, low); chk("b_low0", low, 20); start = 1'b0; advance("b_adv0", 1'b0);
    run_fault(32'h0, 19, low); advance("b_adv1", 1'b0);
    run_fault(32'h400, 19, low); advance("b_adv2", 1'b1);
    chk("b_done", o_done, 1);
    chk("b_err", o_err, 3);
    chk("b_det", o_det, 2);
    chk("b_idx", o_idx, 3);
    begin_session("r_setup");
    chk("r_err_cleared", o_err, 0);
    ora_res = 1'b1;
    repeat (5) tick();
    ora_res = 1'b0;
    chk("r_err5", o_err, 5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("r_tpg_reset", o_tr, 1);
    chk("r_busy", o_busy, 0);
    chk("r_err", o_err, 0);
    chk("r_done", o_done, 0);
    begin_session("x_setup");
    ora_res = 1'b1;
    repeat (2) tick();
    ora_res = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("x_busy", o_busy, 0);
    chk("x_done", o_done, 0);
    chk("x_fil_inc", o_fi, 0);
    chk("x_tpg_reset", o_tr, 1);
    chk("x_err_kept", o_err, 2);
    tick();
    chk("x_still_idle", o_busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("x_err_cleared", o_err, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sel = 1;
    #1;
    begin_session("e_setup");
    run_fault(32'h20, 19, low);
    chk("e_low0", low, 6);
    chk("e_err_run", o_err, 1);
    tpg_end = 1'b1;
    ora_res = 1'b1;
    advance("e_adv0", 1'b0);
    tpg_end = 1'b0;
    ora_res = 1'b0;
    run_fault(32'h0, 19, low);
    chk("e_low1", low, 20);
    advance("e_adv1", 1'b1);
    chk("e_err", o_err, 1);
    chk("e_det", o_det, 1);
    chk("e_idx", o_idx, 2);
    sel = 2;
    #1;
    begin_session("s_setup");
    run_fault(32'hFFFFF, 19, low);
    chk("s_low", low, 20);
    chk("s_err_sat", o_err, 15);
    advance("s_adv", 1'b1);
    chk("s_err_final", o_err, 15);
    chk("s_det", o_det, 1);
    sel = 3;
    #1;
    begin_session("t_setup");
    run_fault(32'h0, -1, low);
    chk("t_low0", low, 16);
    chk("t_flag", o_to, 1);
    advance("t_adv0", 1'b0);
    run_fault(32'h0, 4, low);
    chk("t_low1", low, 5);
    advance("t_adv1", 1'b1);
    chk("t_done", o_done, 1);
    chk("t_flag_sticky", o_to, 1);
    chk("t_idx", o_idx, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t_flag_cleared", o_to, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
